stream_delay_arbiter: RTL and testbench
=======================================

Name: stream_delay_arbiter

Overview:
- Shares one output stream between NumInp valid/ready requesters using round-robin arbitration.
- Inserts a runtime-configurable handshake delay before each granted beat is presented downstream.
- Used in testbench-grade and performance-model interconnect paths to shape AXI-like channel timing.
- Sits between several master-side stream sources and a single slave-side channel.

Parameters:
- NumInp, 4, number of requesters; must be ≥1.
- CntWidth, 4, width of delay_i and of the internal down-counter.
- payload_t, logic, payload type carried unmodified.
- IdxWidth, derived = max(1, $clog2(NumInp)); not user-overridable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- delay_i  input  CntWidth  cycles from grant to oup_valid_o; sampled only at grant.
- inp_payload_i  input  NumInp x payload_t  requester payloads.
- inp_valid_i  input  NumInp  requester valids.
- inp_ready_o  output  NumInp  requester readies.
- oup_payload_o  output  payload_t  payload of the granted requester.
- oup_valid_o  output  1  downstream valid.
- oup_ready_i  input  1  downstream ready.
- idx_o  output  IdxWidth  index of the current or last granted requester.
- busy_o  output  1  high whenever state != Idle.

Behaviour:
- Reset (async, any state): state=Idle, rr pointer=0, idx=0, counter=0.
  - Outputs during reset: oup_valid_o=0, inp_ready_o=0, busy_o=0, idx_o=0.
- States: Idle, Wait, Present.
- Idle, arbitration:
  - Select the first asserted inp_valid_i at or after the rr pointer, scanning upward with wrap.
  - The selection is latched as idx (grant). No valid asserted: remain in Idle, all outputs 0.
- Idle, grant with delay_i==0 (same-cycle pass-through):
  - oup_valid_o=1; inp_ready_o[idx]=oup_ready_i.
  - oup_ready_i=1: handshake completes; stay in Idle.
  - oup_ready_i=0: go to Present.
- Idle, grant with delay_i==1: go to Present.
- Idle, grant with delay_i≥2: load counter=delay_i-1 and go to Wait.
- Wait:
  - oup_valid_o=0; all inp_ready_o=0.
  - Counter decrements each cycle; at counter==1, go to Present.
- Latency: with delay d≥1, oup_valid_o first rises exactly d cycles after the grant cycle.
- Present:
  - oup_valid_o=1; inp_ready_o[idx]=oup_ready_i; all other readies 0.
  - On oup_ready_i=1: handshake completes and the next state is Idle.
- oup_payload_o = inp_payload_i[idx] combinationally in every state (idx is the mux-selected requester in the Idle grant cycle).
- Round-robin update: on each completed handshake, rr pointer = (idx+1) mod NumInp.
  - The pointer never moves without a handshake.
- Back-to-back beats: the next arbitration happens in the Idle cycle following a handshake.
  - With delay_i==0 and oup_ready_i held at 1, the block sustains one beat every cycle. A handshake in Idle stays in Idle.
  - For d≥1, one beat per d+1 cycles.
- Grant lock: once granted, idx and the sampled delay are fixed until the handshake.
  - Changes on delay_i or on other valids are ignored until then.
- Protocol:
  - The granted requester must hold valid and payload stable until its handshake.
  - Deasserting valid early is a violation caught by a simulation assertion; the RTL keeps presenting and needs no recovery.
  - oup_valid_o never drops before its handshake.
- Non-granted requesters always see inp_ready_o=0.
- NumInp==1: arbitration is degenerate; idx_o is always 0.
- delay_i max (2^CntWidth-1): counter must not wrap; latency is exactly 15 cycles at CntWidth=4.

Test Plan:
- delay_i=0; inp_valid_i=4'b0001; oup_ready_i=1 → oup_valid_o=1 and inp_ready_o=4'b0001 in the same cycle; idx_o=0; busy_o stays 0.
- delay_i=3; valid on input 2 at cycle 0; oup_ready_i=1 → oup_valid_o=0 in cycles 0-2, =1 in cycle 3; handshake in cycle 3; idx_o=2.
- delay_i=1; oup_ready_i low for 5 cycles after presentation → oup_valid_o and payload held stable for 5 cycles; handshake on the 6th; no other inp_ready_o asserts.
- All four valids held high, delay_i=0, oup_ready_i=1 → grant order 0,1,2,3,0,1,…; one beat per cycle.
- Delay change and late request: grant with delay_i=5, set delay_i=1 in cycle 1, raise a lower-index valid in cycle 2 → oup_valid_o still rises in cycle 5; the next grant follows rr order from idx+1.
- Reset asserted in Wait (delay_i=10, cycle 4) → outputs 0 immediately; after release, the first grant goes to the lowest asserted index (pointer=0).
- delay_i=15 → oup_valid_o rises exactly at cycle 15; no counter wrap.

Source files
------------

// File: rtl/stream_delay_arbiter_if.sv
// Stream bundle for stream_delay_arbiter: requester side, downstream side,
// delay control and status.
interface stream_delay_arbiter_if #(
    parameter int  NumInp    = 4,
    parameter int  CntWidth  = 4,
    parameter type payload_t = logic
);
    localparam int IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1;

    logic [CntWidth-1:0] delay_i;
    payload_t            inp_payload_i [NumInp];
    logic [NumInp-1:0]   inp_valid_i;
    logic [NumInp-1:0]   inp_ready_o;
    payload_t            oup_payload_o;
    logic                oup_valid_o;
    logic                oup_ready_i;
    logic [IdxWidth-1:0] idx_o;
    logic                busy_o;

    // Arbiter side
    modport slave (
        input  delay_i, inp_payload_i, inp_valid_i, oup_ready_i,
        output inp_ready_o, oup_payload_o, oup_valid_o, idx_o, busy_o
    );

    // Environment side: sources, sink and delay control
    modport master (
        output delay_i, inp_payload_i, inp_valid_i, oup_ready_i,
        input  inp_ready_o, oup_payload_o, oup_valid_o, idx_o, busy_o
    );

    // Passive observer
    modport monitor (
        input delay_i, inp_payload_i, inp_valid_i, oup_ready_i,
        input inp_ready_o, oup_payload_o, oup_valid_o, idx_o, busy_o
    );
endinterface

// File: rtl/stream_delay_arbiter.sv
// Round-robin arbiter sharing one output stream between NumInp requesters,
// with a per-beat handshake delay sampled at grant time.
module stream_delay_arbiter #(
    parameter int  NumInp    = 4,
    parameter int  CntWidth  = 4,
    parameter type payload_t = logic
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    stream_delay_arbiter_if.slave bus
);
    localparam int IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1;

    typedef logic [IdxWidth-1:0] idx_t;
    typedef logic [CntWidth-1:0] cnt_t;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    localparam cnt_t CNT_ZERO = cnt_t'(0);
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam idx_t IDX_ZERO = idx_t'(0);
    localparam idx_t IDX_ONE  = idx_t'(1);
    localparam idx_t IDX_LAST = idx_t'(NumInp - 1);

    state_e            state_r;
    idx_t              rr_r;
    idx_t              idx_r;
    cnt_t              cnt_r;

    idx_t              sel_s;
    logic              found_s;
    logic              grant_s;
    idx_t              cur_idx_s;
    logic              oup_valid_s;
    logic [NumInp-1:0] inp_ready_s;

    function automatic idx_t next_ptr(input idx_t cur);
        if (cur >= IDX_LAST) begin
            return IDX_ZERO;
        end else begin
            return cur + IDX_ONE;
        end
    endfunction

    // First asserted valid at or after the round-robin pointer, with wrap
    always_comb begin : arb_scan
        idx_t cand;
        cand    = IDX_ZERO;
        sel_s   = rr_r;
        found_s = 1'b0;
        for (int i = 0; i < NumInp; i++) begin
            cand = idx_t'((int'(rr_r) + i) % NumInp);
            if (!found_s && bus.inp_valid_i[cand]) begin
                found_s = 1'b1;
                sel_s   = cand;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Output decode; outputs are forced quiet while reset is held so a
    // zero-delay pass-through cannot leak a valid during reset
    always_comb begin
        grant_s     = found_s && rst_ni && (state_r == ST_IDLE);
        cur_idx_s   = idx_r;
        oup_valid_s = 1'b0;
        inp_ready_s = {NumInp{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    cur_idx_s = sel_s;
                    if (bus.delay_i == CNT_ZERO) begin
                        oup_valid_s        = 1'b1;
                        inp_ready_s[sel_s] = bus.oup_ready_i;
                    end else begin
                        oup_valid_s = 1'b0;
                    end
                end else begin
                    cur_idx_s = idx_r;
                end
            end
            ST_WAIT: begin
                oup_valid_s = 1'b0;
            end
            ST_PRESENT: begin
                oup_valid_s        = 1'b1;
                inp_ready_s[idx_r] = bus.oup_ready_i;
            end
            default: begin
                oup_valid_s = 1'b0;
            end
        endcase
    end

    assign bus.oup_valid_o   = oup_valid_s;
    assign bus.inp_ready_o   = inp_ready_s;
    assign bus.oup_payload_o = bus.inp_payload_i[cur_idx_s];
    assign bus.idx_o         = cur_idx_s;
    assign bus.busy_o        = (state_r != ST_IDLE);

    // Grant / delay / present state machine with round-robin pointer update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            rr_r    <= IDX_ZERO;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        idx_r <= sel_s;
                        if (bus.delay_i == CNT_ZERO) begin
                            if (bus.oup_ready_i) begin
                                rr_r <= next_ptr(sel_s);
                            end else begin
                                state_r <= ST_PRESENT;
                            end
                        end else if (bus.delay_i == CNT_ONE) begin
                            state_r <= ST_PRESENT;
                        end else begin
                            // Present on the d-th cycle after grant
                            cnt_r   <= bus.delay_i - CNT_ONE;
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r <= CNT_ONE) begin
                        state_r <= ST_PRESENT;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.oup_ready_i) begin
                        rr_r    <= next_ptr(idx_r);
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PRESENT;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// Protocol checks for stream_delay_arbiter, attached from the environment.
module stream_delay_arbiter_checker (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    stream_delay_arbiter_if.monitor bus
);
    // Granted requester must hold valid until its handshake
    granted_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.busy_o |-> bus.inp_valid_i[bus.idx_o]);

    // Downstream valid stays up until accepted
    oup_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.oup_valid_o && !bus.oup_ready_i) |=> bus.oup_valid_o);
endmodule

// File: tb/tb_stream_delay_arbiter.sv
// Self-checking bench for stream_delay_arbiter: vector table plus
// multi-cycle sequences, payloads checked through a scoreboard queue.
module tb_stream_delay_arbiter;
    typedef logic [7:0] pl_t;

    typedef struct {
        logic [3:0] d;
        logic [3:0] v;
        logic       r;
        logic       ev;
        logic [3:0] er;
        logic [1:0] ei;
        logic       eb;
        logic       push;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    pl_t  pay [4];
    pl_t  sb_q [$];
    vec_t tbl [11];

    stream_delay_arbiter_if #(.NumInp(4), .CntWidth(4), .payload_t(pl_t)) bus ();

    stream_delay_arbiter #(.NumInp(4), .CntWidth(4), .payload_t(pl_t)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    stream_delay_arbiter_checker chk_u (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [3:0] er,
                             input logic [1:0] ei, input logic eb);
        chk({tag, "_valid"}, 32'(bus.oup_valid_o), 32'(ev));
        chk({tag, "_ready"}, 32'(bus.inp_ready_o), 32'(er));
        chk({tag, "_idx"},   32'(bus.idx_o),       32'(ei));
        chk({tag, "_busy"},  32'(bus.busy_o),      32'(eb));
    endtask

    // Drive inputs just after the active edge, then wait for the sampling edge
    task automatic cyc(input logic [3:0] d, input logic [3:0] v, input logic r);
        @(posedge clk);
        #1;
        bus.delay_i     = d;
        bus.inp_valid_i = v;
        bus.oup_ready_i = r;
        @(negedge clk);
    endtask

    task automatic push_exp(input int i);
        sb_q.push_back(pay[i]);
    endtask

    // Scoreboard: every downstream handshake pops the oldest expected payload
    always @(negedge clk) begin
        if (rst_n && bus.oup_valid_o && bus.oup_ready_i) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got handshake payload %0h, expected none", bus.oup_payload_o);
            end else begin
                chk("sb_payload", 32'(bus.oup_payload_o), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) begin
            pay[i]               = pl_t'(8'hA0 + 8'(i * 17));
            bus.inp_payload_i[i] = pay[i];
        end
        bus.delay_i     = 4'd0;
        bus.inp_valid_i = 4'b0001;
        bus.oup_ready_i = 1'b1;
        rst_n           = 1'b0;

        // Reset: outputs quiet even with a pass-through request pending
        @(negedge clk);
        check_out("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        bus.inp_valid_i = 4'b0000;
        rst_n           = 1'b1;

        //            d     valid    rdy   ev    er       ei    eb    push
        tbl[0]  = '{4'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'd0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1};
        tbl[2]  = '{4'd0, 4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1};
        tbl[3]  = '{4'd0, 4'b1111, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1};
        tbl[4]  = '{4'd0, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1};
        tbl[5]  = '{4'd0, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1};
        tbl[6]  = '{4'd0, 4'b1111, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b1};
        tbl[7]  = '{4'd0, 4'b1001, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1};
        tbl[8]  = '{4'd0, 4'b0110, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b1};
        tbl[9]  = '{4'd0, 4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[10] = '{4'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};

        for (int k = 0; k < 11; k++) begin
            @(posedge clk);
            #1;
            bus.delay_i     = tbl[k].d;
            bus.inp_valid_i = tbl[k].v;
            bus.oup_ready_i = tbl[k].r;
            if (tbl[k].push) push_exp(int'(tbl[k].ei));
            @(negedge clk);
            check_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].er, tbl[k].ei, tbl[k].eb);
        end

        // Delay 3 on input 2: valid rises on the third cycle after grant
        push_exp(2);
        for (int c = 0; c < 4; c++) begin
            cyc(4'd3, 4'b0100, 1'b1);
            check_out($sformatf("d3_c%0d", c), c == 3, (c == 3) ? 4'b0100 : 4'b0000,
                      2'd2, c != 0);
        end
        cyc(4'd0, 4'b0000, 1'b1);
        check_out("d3_after", 1'b0, 4'b0000, 2'd2, 1'b0);

        // Delay 1, downstream stalls five cycles; input 1 must never see ready
        push_exp(0);
        cyc(4'd1, 4'b0011, 1'b0);
        check_out("stall_grant", 1'b0, 4'b0000, 2'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cyc(4'd1, 4'b0011, 1'b0);
            check_out($sformatf("stall_c%0d", c), 1'b1, 4'b0000, 2'd0, 1'b1);
            chk("stall_payload", 32'(bus.oup_payload_o), 32'(pay[0]));
        end
        cyc(4'd1, 4'b0011, 1'b1);
        check_out("stall_hs", 1'b1, 4'b0001, 2'd0, 1'b1);
        cyc(4'd0, 4'b0000, 1'b1);
        check_out("stall_after", 1'b0, 4'b0000, 2'd0, 1'b0);

        // Delay sampled at grant; late lower-index request must not steal the beat
        push_exp(2);
        cyc(4'd5, 4'b0100, 1'b1);
        check_out("late_c0", 1'b0, 4'b0000, 2'd2, 1'b0);
        cyc(4'd1, 4'b0100, 1'b1);
        check_out("late_c1", 1'b0, 4'b0000, 2'd2, 1'b1);
        for (int c = 2; c < 6; c++) begin
            cyc(4'd1, 4'b0101, 1'b1);
            check_out($sformatf("late_c%0d", c), c == 5, (c == 5) ? 4'b0100 : 4'b0000,
                      2'd2, 1'b1);
        end
        push_exp(3);
        cyc(4'd0, 4'b1001, 1'b1);
        check_out("late_rr3", 1'b1, 4'b1000, 2'd3, 1'b0);
        push_exp(0);
        cyc(4'd0, 4'b0001, 1'b1);
        check_out("late_rr0", 1'b1, 4'b0001, 2'd0, 1'b0);

        // Reset in the middle of a long wait; pointer returns to 0
        for (int c = 0; c < 4; c++) begin
            cyc(4'd10, 4'b0010, 1'b1);
            check_out($sformatf("rstw_c%0d", c), 1'b0, 4'b0000, 2'd1, c != 0);
        end
        @(posedge clk);
        #1;
        rst_n           = 1'b0;
        bus.delay_i     = 4'd0;
        bus.inp_valid_i = 4'b0011;
        @(negedge clk);
        check_out("rstw_reset", 1'b0, 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(0);
        @(negedge clk);
        check_out("rstw_first", 1'b1, 4'b0001, 2'd0, 1'b0);
        cyc(4'd0, 4'b0000, 1'b1);

        // Maximum delay: valid exactly 15 cycles after grant, no wrap
        push_exp(2);
        for (int c = 0; c < 16; c++) begin
            cyc(4'd15, 4'b0100, 1'b1);
            check_out($sformatf("d15_c%0d", c), c == 15, (c == 15) ? 4'b0100 : 4'b0000,
                      2'd2, c != 0);
        end
        cyc(4'd0, 4'b0000, 1'b1);
        check_out("d15_after", 1'b0, 4'b0000, 2'd2, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
